// File: rtl/instr_fetch_if.sv
// Instruction memory fetch bus: request (rd_en/addr) out, word and ready back.
interface instr_fetch_if;
  logic        imem_rd_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_rdy;

  modport master (
    output imem_rd_en,
    output imem_addr,
    input  imem_data,
    input  imem_rdy
  );

  modport slave (
    input  imem_rd_en,
    input  imem_addr,
    output imem_data,
    output imem_rdy
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, IF/ID register and a RUN/WAIT/HALTED FSM.
// Fetch has zero-cycle latency when memory is ready; misses insert bubbles.
module instr_fetch #(
  parameter logic [15:0] NOP_INSTR = 16'h0000,
  parameter logic [15:0] RESET_PC  = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                j_ctrl,
  input  logic [15:0]         j_pc,
  input  logic                br_taken,
  input  logic [15:0]         br_pc,
  instr_fetch_if.master       imem,
  output logic [15:0]         instr,
  output logic [15:0]         pc_out,
  output logic                valid,
  output logic                mem_wait,
  output logic                halted
);

  typedef enum logic [1:0] {StRun, StWait, StHalted} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [15:0] target;

  // Branch from EX is older than a jump from ID, so it wins.
  assign redirect = br_taken | j_ctrl;
  assign target   = br_taken ? br_pc : j_pc;

  // Next-state and IF/ID update; redirect overrides stall and halt detection.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    if (redirect) begin
      pc_d    = target;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      state_d = StRun;
    end else if (!stall) begin
      unique case (state_q)
        StRun, StWait: begin
          if (imem.imem_rdy) begin
            instr_d  = imem.imem_data;
            pc_d     = pc_q + 16'd1;
            pc_out_d = pc_q + 16'd1;
            valid_d  = 1'b1;
            state_d  = (imem.imem_data[15:12] == 4'b1111) ? StHalted : StRun;
          end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            state_d = StWait;
          end
        end
        StHalted: begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
        default: state_d = StRun;
      endcase
    end
  end

  // State, PC and IF/ID registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StRun;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pc_out_q <= 16'h0000;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  // Moore status outputs and the fetch request.
  always_comb begin
    mem_wait        = (state_q == StWait);
    halted          = (state_q == StHalted);
    imem.imem_rd_en = !rst && !stall && (state_q != StHalted);
    imem.imem_addr  = pc_q;
    instr           = instr_q;
    pc_out          = pc_out_q;
    valid           = valid_q;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, hand sequences
// for halt and asynchronous reset, then randomized traffic against a model.
module tb_instr_fetch;
  localparam logic [15:0] Nop   = 16'hE0E0;
  localparam logic [15:0] RstPc = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, j_ctrl, br_taken, rdy;
  logic [15:0] j_pc, br_pc;
  logic [15:0] instr, pc_out;
  logic        valid, mem_wait, halted;
  logic [15:0] mem [256];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_fetch_if imem_bus ();
  assign imem_bus.imem_data = mem[imem_bus.imem_addr[7:0]];
  assign imem_bus.imem_rdy  = rdy;

  instr_fetch #(
    .NOP_INSTR (Nop),
    .RESET_PC  (RstPc)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .j_ctrl   (j_ctrl),
    .j_pc     (j_pc),
    .br_taken (br_taken),
    .br_pc    (br_pc),
    .imem     (imem_bus),
    .instr    (instr),
    .pc_out   (pc_out),
    .valid    (valid),
    .mem_wait (mem_wait),
    .halted   (halted)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; j_ctrl = 0; br_taken = 0; rdy = 1; j_pc = 0; br_pc = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    @(negedge clk);
    rst = 0;
  endtask

  // Directed table: stall, j, br, rdy, j_pc, br_pc, then expected post-edge values.
  typedef struct packed {
    logic        stall, j, br, rdy;
    logic [15:0] jpc, brpc;
    logic [15:0] e_addr, e_instr, e_pcout;
    logic        e_valid, e_wait;
  } vec_t;
  vec_t tbl [17];

  // Reference model state (booleans, not an encoded FSM).
  logic [15:0] m_pc, m_instr, m_pcout;
  logic        m_valid, m_halted, m_waiting;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    idle_inputs();
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);

    tbl[0]  = '{0,0,0,1, 16'h0, 16'h0,  16'h0001, 16'h1000, 16'h0001, 1,0};
    tbl[1]  = '{0,0,0,1, 16'h0, 16'h0,  16'h0002, 16'h1001, 16'h0002, 1,0};
    tbl[2]  = '{0,0,0,1, 16'h0, 16'h0,  16'h0003, 16'h1002, 16'h0003, 1,0};
    tbl[3]  = '{0,0,0,1, 16'h0, 16'h0,  16'h0004, 16'h1003, 16'h0004, 1,0};
    tbl[4]  = '{0,0,0,1, 16'h0, 16'h0,  16'h0005, 16'h1004, 16'h0005, 1,0};
    tbl[5]  = '{0,0,0,0, 16'h0, 16'h0,  16'h0005, Nop,      16'h0005, 0,1};
    tbl[6]  = '{0,0,0,0, 16'h0, 16'h0,  16'h0005, Nop,      16'h0005, 0,1};
    tbl[7]  = '{0,0,0,1, 16'h0, 16'h0,  16'h0006, 16'h1005, 16'h0006, 1,0};
    tbl[8]  = '{1,1,1,1, 16'h0080, 16'h0040, 16'h0040, Nop, 16'h0006, 0,0};
    tbl[9]  = '{0,0,0,1, 16'h0, 16'h0,  16'h0041, 16'h1040, 16'h0041, 1,0};
    tbl[10] = '{1,0,0,1, 16'h0, 16'h0,  16'h0041, 16'h1040, 16'h0041, 1,0};
    tbl[11] = '{0,1,0,1, 16'hFFFF, 16'h0, 16'hFFFF, Nop,    16'h0041, 0,0};
    tbl[12] = '{0,0,0,1, 16'h0, 16'h0,  16'h0000, 16'h10FF, 16'h0000, 1,0};
    tbl[13] = '{1,0,0,1, 16'h0, 16'h0,  16'h0000, 16'h10FF, 16'h0000, 1,0};
    tbl[14] = '{1,0,0,0, 16'h0, 16'h0,  16'h0000, 16'h10FF, 16'h0000, 1,0};
    tbl[15] = '{1,0,0,1, 16'h0, 16'h0,  16'h0000, 16'h10FF, 16'h0000, 1,0};
    tbl[16] = '{0,0,0,0, 16'h0, 16'h0,  16'h0000, Nop,      16'h0000, 0,1};

    // Reset values while rst is held.
    #12;
    chk("rst_instr", instr, Nop);
    chk("rst_pc_out", pc_out, 16'h0000);
    chk("rst_valid", 16'(valid), 16'h0);
    chk("rst_rd_en", 16'(imem_bus.imem_rd_en), 16'h0);
    chk("rst_wait", 16'(mem_wait), 16'h0);
    chk("rst_halted", 16'(halted), 16'h0);
    chk("rst_addr", imem_bus.imem_addr, RstPc);

    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 17; i++) begin
      stall = tbl[i].stall; j_ctrl = tbl[i].j; br_taken = tbl[i].br; rdy = tbl[i].rdy;
      j_pc = tbl[i].jpc; br_pc = tbl[i].brpc;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_addr", i), imem_bus.imem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_instr", i), instr, tbl[i].e_instr);
      chk($sformatf("tbl%0d_pc_out", i), pc_out, tbl[i].e_pcout);
      chk($sformatf("tbl%0d_valid", i), 16'(valid), 16'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_wait", i), 16'(mem_wait), 16'(tbl[i].e_wait));
      chk($sformatf("tbl%0d_halted", i), 16'(halted), 16'h0);
      @(negedge clk);
    end

    // Halt at PC=9, stay halted, then a branch cancels the halt.
    mem[9] = 16'hF000;
    do_reset();
    j_ctrl = 1; j_pc = 16'h0009;
    @(posedge clk); #1;
    chk("hlt_jump_addr", imem_bus.imem_addr, 16'h0009);
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    chk("hlt_instr", instr, 16'hF000);
    chk("hlt_valid", 16'(valid), 16'h1);
    chk("hlt_halted", 16'(halted), 16'h1);
    chk("hlt_rd_en", 16'(imem_bus.imem_rd_en), 16'h0);
    chk("hlt_addr", imem_bus.imem_addr, 16'h000A);
    @(negedge clk);
    @(posedge clk); #1;
    chk("hlt2_instr", instr, Nop);
    chk("hlt2_valid", 16'(valid), 16'h0);
    chk("hlt2_addr", imem_bus.imem_addr, 16'h000A);
    chk("hlt2_halted", 16'(halted), 16'h1);
    @(negedge clk);
    br_taken = 1; br_pc = 16'h0003;
    @(posedge clk); #1;
    chk("hlt_exit_halted", 16'(halted), 16'h0);
    chk("hlt_exit_addr", imem_bus.imem_addr, 16'h0003);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("hlt_exit_rd_en", 16'(imem_bus.imem_rd_en), 16'h1);
    mem[9] = 16'h1009;

    // Asynchronous reset in the middle of a WAIT.
    rdy = 0;
    @(posedge clk); #1;
    chk("arst_pre_wait", 16'(mem_wait), 16'h1);
    #2;
    rst = 1;
    #1;
    chk("arst_wait", 16'(mem_wait), 16'h0);
    chk("arst_addr", imem_bus.imem_addr, RstPc);
    chk("arst_instr", instr, Nop);
    chk("arst_rd_en", 16'(imem_bus.imem_rd_en), 16'h0);
    @(negedge clk);
    rst = 0; rdy = 1;
    #1;
    chk("arst_rel_addr", imem_bus.imem_addr, RstPc);
    chk("arst_rel_rd_en", 16'(imem_bus.imem_rd_en), 16'h1);
    @(posedge clk); #1;
    chk("arst_first_instr", instr, mem[RstPc[7:0]]);
    chk("arst_first_pc_out", pc_out, RstPc + 16'd1);

    // Randomized traffic against the behavioural model.
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    do_reset();
    m_pc = RstPc; m_instr = Nop; m_pcout = 16'h0000;
    m_valid = 0; m_halted = 0; m_waiting = 0;
    for (int c = 0; c < 400; c++) begin
      logic [15:0] w;
      stall    = ($urandom_range(0, 4) == 0);
      j_ctrl   = ($urandom_range(0, 9) == 0);
      br_taken = ($urandom_range(0, 11) == 0);
      rdy      = ($urandom_range(0, 3) != 0);
      j_pc     = 16'($urandom);
      br_pc    = 16'($urandom);
      #1;
      chk("rnd_rd_en", 16'(imem_bus.imem_rd_en), 16'(!stall && !m_halted));
      chk("rnd_addr", imem_bus.imem_addr, m_pc);
      w = mem[m_pc[7:0]];
      if (br_taken || j_ctrl) begin
        m_pc = br_taken ? br_pc : j_pc;
        m_instr = Nop; m_valid = 0; m_halted = 0; m_waiting = 0;
      end else if (!stall) begin
        if (m_halted) begin
          m_instr = Nop; m_valid = 0;
        end else if (rdy) begin
          m_instr = w; m_pc = m_pc + 16'd1; m_pcout = m_pc; m_valid = 1;
          m_waiting = 0; m_halted = (w >= 16'hF000);
        end else begin
          m_instr = Nop; m_valid = 0; m_waiting = 1;
        end
      end
      @(posedge clk); #1;
      chk("rnd_instr", instr, m_instr);
      chk("rnd_pc_out", pc_out, m_pcout);
      chk("rnd_valid", 16'(valid), 16'(m_valid));
      chk("rnd_wait", 16'(mem_wait), 16'(m_waiting));
      chk("rnd_halted", 16'(halted), 16'(m_halted));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
